// File: rtl/e203_ifu_pcgen_pkg.sv
// Shared types and constants for the IFU PC generator.
// The HALT state exists only when E203_IFU_PCGEN_HALT_EN is defined.
package e203_ifu_pcgen_pkg;

  localparam int ST_W     = 3;
  localparam int INC_RV32 = 4;
  localparam int INC_RV16 = 2;

  typedef enum logic [ST_W-1:0] {
    ST_RST   = 3'd0,
    ST_REQ   = 3'd1,
    ST_OUTS  = 3'd2,
    ST_STALL = 3'd3
`ifdef E203_IFU_PCGEN_HALT_EN
    , ST_HALT = 3'd4
`endif
  } state_e;

  // Where a halt parks the FSM; unreachable when halt support is compiled out.
`ifdef E203_IFU_PCGEN_HALT_EN
  localparam state_e ST_PARK = ST_HALT;
`else
  localparam state_e ST_PARK = ST_REQ;
`endif

  typedef enum logic [1:0] {
    SEL_FLUSH = 2'd0,
    SEL_RTVEC = 2'd1,
    SEL_PRDT  = 2'd2,
    SEL_SEQ   = 2'd3
  } sel_e;

endpackage

// File: rtl/e203_ifu_pcgen_adder.sv
// Operand mux plus the single next-PC adder; bit 0 of the result is cleared.
import e203_ifu_pcgen_pkg::*;

module e203_ifu_pcgen_adder #(
  parameter int PC_SIZE = 32
) (
  input  sel_e               sel,
  input  logic [PC_SIZE-1:0] flush_op1,
  input  logic [PC_SIZE-1:0] flush_op2,
  input  logic [PC_SIZE-1:0] prdt_op1,
  input  logic [PC_SIZE-1:0] prdt_op2,
  input  logic [PC_SIZE-1:0] rtvec,
  input  logic [PC_SIZE-1:0] seq_base,
  input  logic               is_rv32,
  output logic [PC_SIZE-1:0] next_pc
);

  logic [PC_SIZE-1:0] op1, op2, sum;

  always_comb begin
    op1 = seq_base;
    op2 = is_rv32 ? PC_SIZE'(INC_RV32) : PC_SIZE'(INC_RV16);
    case (sel)
      SEL_FLUSH: begin op1 = flush_op1; op2 = flush_op2; end
      SEL_RTVEC: begin op1 = rtvec;     op2 = '0;        end
      SEL_PRDT:  begin op1 = prdt_op1;  op2 = prdt_op2;  end
      default:   ;
    endcase
  end

  assign sum     = op1 + op2;
  assign next_pc = sum & ~PC_SIZE'(1);

endmodule

// File: rtl/e203_ifu_pcgen.sv
// IFU PC generator: PC register, one-outstanding fetch FSM, flush/stall/drop handling.
// Optional debug halt support is enabled by defining E203_IFU_PCGEN_HALT_EN.
import e203_ifu_pcgen_pkg::*;

module e203_ifu_pcgen #(
  parameter int PC_SIZE = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PC_SIZE-1:0] pc_rtvec,
  output logic               ifu_req_valid,
  input  logic               ifu_req_ready,
  output logic [PC_SIZE-1:0] ifu_req_pc,
  output logic               ifu_req_seq,
  input  logic               ifu_rsp_valid,
  output logic               ifu_rsp_ready,
  output logic               ir_load,
  output logic [PC_SIZE-1:0] pc,
  output logic               pc_vld,
  input  logic               dec_i_valid,
  input  logic               dec_is_rv32,
  input  logic               prdt_taken,
  input  logic               bpu_wait,
  input  logic [PC_SIZE-1:0] prdt_pc_add_op1,
  input  logic [PC_SIZE-1:0] prdt_pc_add_op2,
  input  logic               pipe_flush_req,
  output logic               pipe_flush_ack,
  input  logic [PC_SIZE-1:0] pipe_flush_add_op1,
  input  logic [PC_SIZE-1:0] pipe_flush_add_op2,
  input  logic               halt_req,
  output logic               halt_ack
);

  state_e             state, state_nxt;
  sel_e               sel;
  logic [PC_SIZE-1:0] req_pc_q, req_pc_nxt, next_pc, seq_base, cand_pc;
  logic               req_seq_q, req_seq_nxt, cand_seq;
  logic               flush_pend, flush_pend_nxt, rsp_drop, halt_go;

`ifdef E203_IFU_PCGEN_HALT_EN
  assign halt_go  = halt_req;
  assign halt_ack = (state == ST_HALT);
`else
  logic unused_halt;
  assign unused_halt = halt_req;
  assign halt_go     = 1'b0;
  assign halt_ack    = 1'b0;
`endif

  assign ifu_rsp_ready  = 1'b1;
  assign pipe_flush_ack = pipe_flush_req & (state != ST_RST);
  // While a response is arriving the instruction being decoded is the outstanding one.
  assign seq_base       = (state == ST_OUTS) ? req_pc_q : pc;

  always_comb begin
    if (state == ST_RST)                sel = SEL_RTVEC;
    else if (pipe_flush_req)            sel = SEL_FLUSH;
    else if (dec_i_valid & prdt_taken)  sel = SEL_PRDT;
    else                                sel = SEL_SEQ;
  end

  e203_ifu_pcgen_adder #(.PC_SIZE(PC_SIZE)) u_adder (
    .sel       (sel),
    .flush_op1 (pipe_flush_add_op1),
    .flush_op2 (pipe_flush_add_op2),
    .prdt_op1  (prdt_pc_add_op1),
    .prdt_op2  (prdt_pc_add_op2),
    .rtvec     (pc_rtvec),
    .seq_base  (seq_base),
    .is_rv32   (dec_is_rv32),
    .next_pc   (next_pc)
  );

  always_comb begin
    state_nxt      = state;
    req_pc_nxt     = req_pc_q;
    req_seq_nxt    = req_seq_q;
    flush_pend_nxt = flush_pend;
    ifu_req_valid  = 1'b0;
    ifu_req_pc     = req_pc_q;
    ifu_req_seq    = req_seq_q;
    ir_load        = 1'b0;
    rsp_drop       = 1'b0;
    cand_pc        = next_pc;
    cand_seq       = 1'b0;
    case (state)
      ST_RST: begin
        state_nxt   = ST_REQ;
        req_pc_nxt  = next_pc;
        req_seq_nxt = 1'b0;
      end
      ST_REQ: begin
        if (pipe_flush_req) begin
          ifu_req_pc  = next_pc;
          ifu_req_seq = 1'b0;
          req_pc_nxt  = next_pc;
          req_seq_nxt = 1'b0;
        end
        if (halt_go) state_nxt = ST_PARK;
        else begin
          ifu_req_valid = 1'b1;
          if (ifu_req_ready) state_nxt = ST_OUTS;
        end
      end
      ST_OUTS: begin
        // The outstanding PC is no longer needed once a flush dooms its response.
        if (pipe_flush_req) begin
          req_pc_nxt     = next_pc;
          req_seq_nxt    = 1'b0;
          flush_pend_nxt = 1'b1;
        end
        if (ifu_rsp_valid) begin
          flush_pend_nxt = 1'b0;
          ir_load        = ~flush_pend & ~pipe_flush_req;
          rsp_drop       = ~ir_load;
          cand_pc        = (flush_pend & ~pipe_flush_req) ? req_pc_q : next_pc;
          cand_seq       = ir_load & (sel == SEL_SEQ);
          req_pc_nxt     = cand_pc;
          req_seq_nxt    = cand_seq;
          if (ir_load & bpu_wait) state_nxt = ST_STALL;
          else if (halt_go)       state_nxt = ST_PARK;
          else begin
            ifu_req_valid = 1'b1;
            ifu_req_pc    = cand_pc;
            ifu_req_seq   = cand_seq;
            state_nxt     = ifu_req_ready ? ST_OUTS : ST_REQ;
          end
        end
      end
      ST_STALL: begin
        if (pipe_flush_req | ~bpu_wait) begin
          req_pc_nxt  = next_pc;
          req_seq_nxt = (sel == SEL_SEQ);
          state_nxt   = halt_go ? ST_PARK : ST_REQ;
        end
      end
`ifdef E203_IFU_PCGEN_HALT_EN
      ST_HALT: begin
        if (pipe_flush_req) begin
          req_pc_nxt  = next_pc;
          req_seq_nxt = 1'b0;
        end
        if (~halt_go) state_nxt = ST_REQ;
      end
`endif
      default: state_nxt = ST_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RST;
      req_pc_q   <= '0;
      req_seq_q  <= 1'b0;
      flush_pend <= 1'b0;
      pc         <= '0;
      pc_vld     <= 1'b0;
    end else begin
      state      <= state_nxt;
      req_pc_q   <= req_pc_nxt;
      req_seq_q  <= req_seq_nxt;
      flush_pend <= flush_pend_nxt;
      if (ir_load) begin
        pc     <= req_pc_q;
        pc_vld <= 1'b1;
      end else if (rsp_drop) begin
        pc_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_e203_ifu_pcgen.sv
// Self-checking bench for e203_ifu_pcgen: fetch-request scoreboard plus per-scenario checks.
module tb_e203_ifu_pcgen;

  typedef struct { logic [31:0] pc; logic seq; } req_t;

  logic        clk, rst_n;
  logic [31:0] pc_rtvec, ifu_req_pc, pc, prdt_op1, prdt_op2, flush_op1, flush_op2;
  logic        ifu_req_valid, ifu_req_ready, ifu_req_seq, ifu_rsp_valid, ifu_rsp_ready;
  logic        ir_load, pc_vld, dec_i_valid, dec_is_rv32, prdt_taken, bpu_wait;
  logic        pipe_flush_req, pipe_flush_ack, halt_req, halt_ack;

  int   total = 0;
  int   bad   = 0;
  req_t sbq[$];
  req_t sb_e;
  logic [31:0] cur;

  e203_ifu_pcgen #(.PC_SIZE(32)) dut (
    .clk(clk), .rst_n(rst_n), .pc_rtvec(pc_rtvec),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_req_pc(ifu_req_pc), .ifu_req_seq(ifu_req_seq),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
    .ir_load(ir_load), .pc(pc), .pc_vld(pc_vld),
    .dec_i_valid(dec_i_valid), .dec_is_rv32(dec_is_rv32), .prdt_taken(prdt_taken),
    .bpu_wait(bpu_wait), .prdt_pc_add_op1(prdt_op1), .prdt_pc_add_op2(prdt_op2),
    .pipe_flush_req(pipe_flush_req), .pipe_flush_ack(pipe_flush_ack),
    .pipe_flush_add_op1(flush_op1), .pipe_flush_add_op2(flush_op2),
    .halt_req(halt_req), .halt_ack(halt_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
    $fatal(1);
  end

  // Scoreboard: every accepted fetch request must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && ifu_req_valid && ifu_req_ready) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got pc=%h seq=%b, no request expected", ifu_req_pc, ifu_req_seq);
      end else begin
        sb_e = sbq.pop_front();
        if (ifu_req_pc !== sb_e.pc || ifu_req_seq !== sb_e.seq) begin
          bad++;
          $display("FAIL sb_req: got pc=%h seq=%b want pc=%h seq=%b", ifu_req_pc, ifu_req_seq, sb_e.pc, sb_e.seq);
        end
      end
    end
  end

  task automatic nxt(); @(posedge clk); #1; endtask
  task automatic mid(); @(negedge clk); endtask
  task automatic exp_req(input logic [31:0] p, input logic s); sbq.push_back('{pc: p, seq: s}); endtask

  task automatic idle_inputs();
    ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b0; dec_i_valid = 1'b0; dec_is_rv32 = 1'b1;
    prdt_taken = 1'b0; bpu_wait = 1'b0; pipe_flush_req = 1'b0; halt_req = 1'b0;
    prdt_op1 = '0; prdt_op2 = '0; flush_op1 = '0; flush_op2 = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle_inputs(); pc_rtvec = 32'h8000_0000;
    pipe_flush_req = 1'b1; flush_op1 = 32'h40;
    repeat (2) @(posedge clk);
    mid();
    total++; if (ifu_req_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", ifu_req_valid); end
    total++; if (ir_load !== 1'b0) begin bad++; $display("FAIL rst_ir_load: got %b want 0", ir_load); end
    total++; if (pc !== 32'h0 || pc_vld !== 1'b0) begin bad++; $display("FAIL rst_pc: got %h/%b want 0/0", pc, pc_vld); end
    total++; if (pipe_flush_ack !== 1'b0 || halt_ack !== 1'b0) begin bad++; $display("FAIL rst_acks: got %b/%b want 0/0", pipe_flush_ack, halt_ack); end
    total++; if (ifu_rsp_ready !== 1'b1) begin bad++; $display("FAIL rsp_ready: got %b want 1", ifu_rsp_ready); end
    nxt(); rst_n = 1'b1;
    mid();
    total++; if (ifu_req_valid !== 1'b0 || pipe_flush_ack !== 1'b0) begin bad++; $display("FAIL rst_state: valid=%b ack=%b want 0/0", ifu_req_valid, pipe_flush_ack); end
    nxt(); pipe_flush_req = 1'b0; exp_req(32'h8000_0000, 1'b0);
    mid();
    total++; if (ifu_req_valid !== 1'b1) begin bad++; $display("FAIL first_req_valid: got %b want 1", ifu_req_valid); end
    nxt(); ifu_rsp_valid = 1'b1; exp_req(32'h8000_0004, 1'b1);
    mid();
    total++; if (ir_load !== 1'b1) begin bad++; $display("FAIL first_load: got %b want 1", ir_load); end
    nxt(); idle_inputs();
    mid();
    total++; if (pc !== 32'h8000_0000 || pc_vld !== 1'b1) begin bad++; $display("FAIL first_pc: got %h/%b want 80000000/1", pc, pc_vld); end
  endtask

  task automatic test_seq();
    nxt(); ifu_rsp_valid = 1'b1; pipe_flush_req = 1'b1; flush_op1 = 32'h100; exp_req(32'h100, 1'b0);
    mid();
    total++; if (pipe_flush_ack !== 1'b1 || ir_load !== 1'b0) begin bad++; $display("FAIL flush_rsp_same: ack=%b load=%b want 1/0", pipe_flush_ack, ir_load); end
    nxt(); idle_inputs();
    mid();
    total++; if (pc_vld !== 1'b0 || pc !== 32'h8000_0000) begin bad++; $display("FAIL drop_pcvld: got %h/%b want 80000000/0", pc, pc_vld); end
    nxt(); ifu_rsp_valid = 1'b1; dec_is_rv32 = 1'b0; exp_req(32'h102, 1'b1);
    mid();
    total++; if (ir_load !== 1'b1) begin bad++; $display("FAIL rv16_load: got %b want 1", ir_load); end
    nxt(); dec_is_rv32 = 1'b1; exp_req(32'h106, 1'b1);
    mid();
    total++; if (pc !== 32'h100) begin bad++; $display("FAIL rv16_pc: got %h want 100", pc); end
    nxt(); idle_inputs();
    mid();
    total++; if (pc !== 32'h102 || pc_vld !== 1'b1) begin bad++; $display("FAIL rv32_pc: got %h/%b want 102/1", pc, pc_vld); end
  endtask

  task automatic test_prdt();
    nxt(); ifu_rsp_valid = 1'b1; dec_i_valid = 1'b1; prdt_taken = 1'b1;
    prdt_op1 = 32'h200; prdt_op2 = 32'hFFFF_FFF0; exp_req(32'h1F0, 1'b0);
    mid();
    total++; if (ifu_req_pc !== 32'h1F0 || ifu_req_seq !== 1'b0) begin bad++; $display("FAIL prdt_wrap: got %h/%b want 1f0/0", ifu_req_pc, ifu_req_seq); end
    nxt(); prdt_op1 = 32'h301; prdt_op2 = 32'h2; exp_req(32'h302, 1'b0);
    mid();
    nxt(); dec_i_valid = 1'b0; exp_req(32'h306, 1'b1);
    mid();
    total++; if (ir_load !== 1'b1) begin bad++; $display("FAIL prdt_nodec_load: got %b want 1", ir_load); end
    nxt(); idle_inputs();
    mid();
    total++; if (pc !== 32'h302) begin bad++; $display("FAIL prdt_pc: got %h want 302", pc); end
  endtask

  task automatic test_flush_outs();
    nxt(); pipe_flush_req = 1'b1; flush_op1 = 32'h400; flush_op2 = 32'h4;
    mid();
    total++; if (pipe_flush_ack !== 1'b1 || ifu_req_valid !== 1'b0) begin bad++; $display("FAIL flush_outs_ack: ack=%b valid=%b want 1/0", pipe_flush_ack, ifu_req_valid); end
    nxt(); idle_inputs(); ifu_rsp_valid = 1'b1; exp_req(32'h404, 1'b0);
    mid();
    total++; if (ir_load !== 1'b0 || ifu_req_valid !== 1'b1) begin bad++; $display("FAIL flush_pend_drop: load=%b valid=%b want 0/1", ir_load, ifu_req_valid); end
    nxt(); idle_inputs();
    mid();
    total++; if (pc_vld !== 1'b0 || pc !== 32'h302) begin bad++; $display("FAIL flush_pend_pc: got %h/%b want 302/0", pc, pc_vld); end
  endtask

  task automatic test_ready_hold();
    nxt(); ifu_rsp_valid = 1'b1; ifu_req_ready = 1'b0;
    mid();
    total++; if (ir_load !== 1'b1 || ifu_req_pc !== 32'h408) begin bad++; $display("FAIL hold_issue: load=%b pc=%h want 1/408", ir_load, ifu_req_pc); end
    nxt(); ifu_rsp_valid = 1'b0; dec_is_rv32 = 1'b0; dec_i_valid = 1'b1; prdt_taken = 1'b1; prdt_op1 = 32'h900;
    mid();
    total++; if (ifu_req_valid !== 1'b1 || ifu_req_pc !== 32'h408 || ifu_req_seq !== 1'b1) begin bad++; $display("FAIL hold_stable: got %b/%h/%b want 1/408/1", ifu_req_valid, ifu_req_pc, ifu_req_seq); end
    nxt(); dec_i_valid = 1'b0; prdt_taken = 1'b0; pipe_flush_req = 1'b1; flush_op1 = 32'h500; flush_op2 = 32'h0;
    mid();
    total++; if (pipe_flush_ack !== 1'b1 || ifu_req_pc !== 32'h500 || ifu_req_seq !== 1'b0) begin bad++; $display("FAIL hold_flush: got %b/%h/%b want 1/500/0", pipe_flush_ack, ifu_req_pc, ifu_req_seq); end
    nxt(); idle_inputs(); exp_req(32'h500, 1'b0);
    mid();
    total++; if (pc !== 32'h404 || pc_vld !== 1'b1) begin bad++; $display("FAIL hold_pc: got %h/%b want 404/1", pc, pc_vld); end
  endtask

  task automatic test_stall();
    nxt(); ifu_rsp_valid = 1'b1; bpu_wait = 1'b1;
    mid();
    total++; if (ir_load !== 1'b1 || ifu_req_valid !== 1'b0) begin bad++; $display("FAIL stall_enter: load=%b valid=%b want 1/0", ir_load, ifu_req_valid); end
    for (int i = 0; i < 2; i++) begin
      nxt(); ifu_rsp_valid = 1'b0;
      mid();
      total++; if (ifu_req_valid !== 1'b0) begin bad++; $display("FAIL stall_hold%0d: valid=%b want 0", i, ifu_req_valid); end
    end
    nxt(); bpu_wait = 1'b0; dec_i_valid = 1'b1; prdt_taken = 1'b1; prdt_op1 = 32'h600; prdt_op2 = 32'h10;
    mid();
    total++; if (ifu_req_valid !== 1'b0 || pc !== 32'h500) begin bad++; $display("FAIL stall_drop: valid=%b pc=%h want 0/500", ifu_req_valid, pc); end
    nxt(); idle_inputs(); exp_req(32'h610, 1'b0);
    mid();
    total++; if (ifu_req_valid !== 1'b1) begin bad++; $display("FAIL stall_resume: valid=%b want 1", ifu_req_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] last;
    logic        r;
    cur = 32'h610;
    last = cur;
    for (int i = 0; i < 8; i++) begin
      nxt(); r = 1'($urandom_range(0, 1));
      ifu_rsp_valid = 1'b1; dec_is_rv32 = r;
      last = cur; cur = cur + (r ? 32'd4 : 32'd2); exp_req(cur, 1'b1);
      mid();
      total++; if (ir_load !== 1'b1) begin bad++; $display("FAIL b2b_load%0d: got %b want 1", i, ir_load); end
    end
    nxt(); idle_inputs();
    mid();
    total++; if (pc !== last) begin bad++; $display("FAIL b2b_pc: got %h want %h", pc, last); end
  endtask

`ifdef E203_IFU_PCGEN_HALT_EN
  task automatic test_halt();
    nxt(); halt_req = 1'b1;
    mid();
    total++; if (ifu_req_valid !== 1'b0 || halt_ack !== 1'b0) begin bad++; $display("FAIL halt_outs: valid=%b ack=%b want 0/0", ifu_req_valid, halt_ack); end
    nxt(); ifu_rsp_valid = 1'b1;
    mid();
    total++; if (ir_load !== 1'b1 || ifu_req_valid !== 1'b0) begin bad++; $display("FAIL halt_rsp: load=%b valid=%b want 1/0", ir_load, ifu_req_valid); end
    for (int i = 0; i < 2; i++) begin
      nxt(); ifu_rsp_valid = 1'b0;
      mid();
      total++; if (halt_ack !== 1'b1 || ifu_req_valid !== 1'b0) begin bad++; $display("FAIL halt_hold%0d: ack=%b valid=%b want 1/0", i, halt_ack, ifu_req_valid); end
    end
    nxt(); halt_req = 1'b0; exp_req(cur + 32'd4, 1'b1);
    mid();
    nxt();
    mid();
    total++; if (halt_ack !== 1'b0 || ifu_req_pc !== cur + 32'd4) begin bad++; $display("FAIL halt_resume: ack=%b pc=%h want 0/%h", halt_ack, ifu_req_pc, cur + 32'd4); end
  endtask
`else
  task automatic test_halt();
    nxt(); halt_req = 1'b1; ifu_rsp_valid = 1'b1; exp_req(cur + 32'd4, 1'b1);
    mid();
    total++; if (ifu_req_valid !== 1'b1 || halt_ack !== 1'b0) begin bad++; $display("FAIL halt_ignored: valid=%b ack=%b want 1/0", ifu_req_valid, halt_ack); end
    nxt(); idle_inputs();
    mid();
  endtask
`endif

  initial begin
    test_reset();
    test_seq();
    test_prdt();
    test_flush_outs();
    test_ready_hold();
    test_stall();
    test_back_to_back();
    test_halt();
    nxt(); idle_inputs();
    mid();
    total++; if (sbq.size() != 0) begin bad++; $display("FAIL sb_drain: %0d expected requests never issued, want 0", sbq.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
